fifo_dc: RTL and testbench

Single-clock synchronous FIFO with a show-ahead (first-word-fall-through) read port. Storage depth is 2**N words of W bits. Used as a small elastic buffer between a producer and a consumer in the same clock domain. Exposes full/empty flags and an occupancy count.

---
 rtl/fifo_dc_ram.sv | 27 ++
 rtl/fifo_dc.sv | 86 ++++++++
 tb/tb_fifo_dc.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fifo_dc_ram.sv
// rtl/fifo_dc_ram.sv - 2**N x W simple dual-port array, synchronous write, asynchronous read
module fifo_dc_ram #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         we_int,
  input  logic [N-1:0] waddr,
  input  logic [W-1:0] wd,
  input  logic [N-1:0] raddr,
  output logic [W-1:0] q
);

  localparam int DEPTH = 2**N;

  // Deliberately not reset so the array maps onto plain storage.
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_int) begin
      mem[waddr] <= wd;
    end
  end

  assign q = mem[raddr];

endmodule

// File: rtl/fifo_dc.sv
// rtl/fifo_dc.sv - single-clock show-ahead FIFO; sticky ovf/udf flags built only with FIFO_DC_ERR_EN
module fifo_dc #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] wd,
  input  logic         re,
  output logic [W-1:0] rd,
  output logic         full,
  output logic         empty,
  output logic [N:0]   count,
  output logic         ovf,
  output logic         udf
);

  logic [N:0]   wptr;
  logic [N:0]   rptr;
  logic [W-1:0] q;
  logic         wr_ok;
  logic         rd_ok;

  // The extra MSB on each pointer separates full from empty when the addresses match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[N-1:0] == rptr[N-1:0]) && (wptr[N] != rptr[N]);
  assign count = wptr - rptr;

  assign wr_ok = we && !full;
  assign rd_ok = re && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  fifo_dc_ram #(
    .W(W),
    .N(N)
  ) u_ram (
    .clk    (clk),
    .we_int (wr_ok),
    .waddr  (wptr[N-1:0]),
    .wd     (wd),
    .raddr  (rptr[N-1:0]),
    .q      (q)
  );

  assign rd = empty ? '0 : q;

`ifdef FIFO_DC_ERR_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (we && full) begin
        ovf_q <= 1'b1;
      end
      if (re && empty) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_dc.sv
// tb/tb_fifo_dc.sv - scoreboard bench for fifo_dc (W=4, N=2); expectations follow FIFO_DC_ERR_EN
module tb_fifo_dc;

  localparam int W = 4;
  localparam int N = 2;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         we  = 1'b0;
  logic [W-1:0] wd  = '0;
  logic         re  = 1'b0;
  logic [W-1:0] rd;
  logic         full;
  logic         empty;
  logic [N:0]   count;
  logic         ovf;
  logic         udf;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] sb[$];
  logic         ovf_m = 1'b0;
  logic         udf_m = 1'b0;

  fifo_dc #(
    .W(W),
    .N(N)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .wd    (wd),
    .re    (re),
    .rd    (rd),
    .full  (full),
    .empty (empty),
    .count (count),
    .ovf   (ovf),
    .udf   (udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    logic [W-1:0] head;
    head = (sb.size() != 0) ? sb[0] : '0;
    check("count", 32'(count), 32'(sb.size()));
    check("empty", 32'(empty), 32'(sb.size() == 0));
    check("full",  32'(full),  32'(sb.size() == DEPTH));
    check("rd",    32'(rd),    32'(head));
    check("ovf",   32'(ovf),   32'(ovf_m));
    check("udf",   32'(udf),   32'(udf_m));
  endtask

  // Checks the pre-edge outputs, drives one cycle, and advances the model.
  task automatic cycle(input logic w, input logic [W-1:0] d, input logic r);
    bit m_full;
    bit m_empty;
    logic [W-1:0] popped;
    @(negedge clk);
    check_state();
    we = w;
    wd = d;
    re = r;
    m_full  = (sb.size() == DEPTH);
    m_empty = (sb.size() == 0);
    if (r && !m_empty) begin
      popped = sb.pop_front();
      check("pop", 32'(rd), 32'(popped));
    end
    if (w && !m_full) begin
      sb.push_back(d);
    end
`ifdef FIFO_DC_ERR_EN
    if (w && m_full)  ovf_m = 1'b1;
    if (r && m_empty) udf_m = 1'b1;
`endif
    @(posedge clk);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    we  = 1'b0;
    re  = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    ovf_m = 1'b0;
    udf_m = 1'b0;
  endtask

  initial begin
    do_reset(10);
    cycle(1'b0, 4'h0, 1'b0);

    // Fill, then attempt a write while full.
    cycle(1'b1, 4'b0001, 1'b0);
    cycle(1'b1, 4'b0010, 1'b0);
    cycle(1'b1, 4'b0100, 1'b0);
    cycle(1'b1, 4'b1000, 1'b0);
    cycle(1'b1, 4'b1111, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);

    // Full with simultaneous write and read: only the read happens.
    cycle(1'b1, 4'b1001, 1'b1);

    // Drain, then read while empty.
    repeat (3) cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 1'b0);

    // Empty with simultaneous write and read: only the write happens.
    cycle(1'b1, 4'b0101, 1'b1);
    cycle(1'b1, 4'b0110, 1'b0);
    cycle(1'b1, 4'b0111, 1'b1);
    cycle(1'b1, 4'b1010, 1'b1);
    cycle(1'b0, 4'h0, 1'b0);

    // Stream across pointer wrap with interleaved reads.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 4'(i), (i % 3) != 0);
    end
    while (sb.size() != 0) cycle(1'b0, 4'h0, 1'b1);

    // Reset with two words held.
    cycle(1'b1, 4'b1100, 1'b0);
    cycle(1'b1, 4'b0011, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    do_reset(1);
    cycle(1'b0, 4'h0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
